// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   localparam logic [7:0] FRAME_CNT_MAX = 8'hFF;

   // Width of a counter that indexes data_w bits (never narrower than 1).
   function automatic int cnt_width(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

endpackage

// File: rtl/frame_rx_shift.sv
// Receive shift register (LSB-first) with a running XOR of the shifted-in bits.
module frame_rx_shift #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              shift_en,
   input  logic              din,
   input  logic              load_clr,
   output logic [DATA_W-1:0] word,
   output logic              parity
);

   logic [DATA_W-1:0] shift_reg;
   logic              par_reg;

   // Bits enter at the MSB and walk right, so the first bit lands in word[0].
   always_ff @(posedge clk) begin
      if (clr || load_clr) begin
         shift_reg <= '0;
         par_reg   <= 1'b0;
      end else if (shift_en) begin
         shift_reg <= {din, shift_reg[DATA_W-1:1]};
         par_reg   <= par_reg ^ din;
      end
   end

   assign word   = shift_reg;
   assign parity = par_reg;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, DATA_W bits LSB first, optional parity, stop.
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              din,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy,
   output logic [7:0]        frame_cnt
);

   localparam int             CW       = cnt_width(DATA_W);
   localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_W - 1);
   localparam logic           ODD_BIT  = (PARITY_ODD != 0);
   localparam logic           HAS_PAR  = (PARITY_EN != 0);

   state_t            state_reg, state_next;
   logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
   logic              pbit_reg, pbit_next;
   logic [DATA_W-1:0] data_reg, data_next;
   logic              valid_reg, valid_next;
   logic              perr_reg, perr_next;
   logic              ferr_reg, ferr_next;
   logic [7:0]        cnt_reg, cnt_next;

   logic              shift_en;
   logic              load_clr;
   logic [DATA_W-1:0] word;
   logic              acc;
   logic              parity_ok;

   frame_rx_shift #(.DATA_W(DATA_W)) u_shift (
      .clk      (clk),
      .clr      (clr),
      .shift_en (shift_en),
      .din      (din),
      .load_clr (load_clr),
      .word     (word),
      .parity   (acc)
   );

   assign parity_ok = !HAS_PAR || ((acc ^ pbit_reg) == ODD_BIT);

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         pbit_reg    <= 1'b0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         perr_reg    <= 1'b0;
         ferr_reg    <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         pbit_reg    <= pbit_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         perr_reg    <= perr_next;
         ferr_reg    <= ferr_next;
         cnt_reg     <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      pbit_next    = pbit_reg;
      data_next    = data_reg;
      cnt_next     = cnt_reg;
      valid_next   = 1'b0;
      perr_next    = 1'b0;
      ferr_next    = 1'b0;
      shift_en     = 1'b0;
      load_clr     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!din) begin
               state_next   = DATA;
               bit_cnt_next = '0;
               load_clr     = 1'b1;
            end
         end
         DATA: begin
            shift_en = 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
               state_next = HAS_PAR ? PARITY : STOP;
            end else begin
               bit_cnt_next = bit_cnt_reg + CW'(1);
            end
         end
         PARITY: begin
            pbit_next  = din;
            state_next = STOP;
         end
         STOP: begin
            // A bad stop bit wins over parity: the frame is untrustworthy.
            if (din) begin
               state_next = IDLE;
               if (parity_ok) begin
                  valid_next = 1'b1;
                  data_next  = word;
                  if (cnt_reg != FRAME_CNT_MAX) begin
                     cnt_next = cnt_reg + 8'd1;
                  end
               end else begin
                  perr_next = 1'b1;
               end
            end else begin
               ferr_next  = 1'b1;
               state_next = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (din) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign data       = data_reg;
   assign valid      = valid_reg;
   assign parity_err = perr_reg;
   assign frame_err  = ferr_reg;
   assign frame_cnt  = cnt_reg;
   assign busy       = (state_reg == DATA) || (state_reg == PARITY) || (state_reg == STOP);

endmodule
